serial_mac_ac1_seq: RTL and testbench

// - Upstream stage of the AC2 shift-register accumulator in the serial MAC (no AC3) datapath.
// - Accepts one operand set per handshake: M unsigned Pa-bit activations and M unsigned Pw-bit weights.
// - Walks the weights LSB-first, one bit per cycle. Each cycle it forms the AC1 partial sum
//   (sum of activations whose weight bit is 1), adds the AC2 feedback and drives the AC2 controls.
// - After Pw cycles the AC2 register holds sum_k act_k*wgt_k, and this block signals out_valid.

---
 rtl/serial_mac_pkg.sv | 11 +
 rtl/serial_mac_ac1_seq_if.sv | 31 +++
 rtl/serial_mac_ac1_seq_ac1_tree.sv | 34 +++
 rtl/serial_mac_ac1_seq.sv | 97 +++++++++
 tb/tb_serial_mac_ac1_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/serial_mac_pkg.sv
// Shared types and width helper for the serial MAC datapath (AC1 stage, AC2 register, top level).
package serial_mac_pkg;

  // Width of the AC1 partial sum: M activations of Pa bits summed without overflow.
  function automatic int ac_w(input int m, input int pa);
    return $clog2(m) + pa;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} smac_state_t;

endpackage

// File: rtl/serial_mac_ac1_seq_if.sv
// Operand handshake, AC2 feedback/control and result handshake of the AC1 sequencer.
interface serial_mac_ac1_seq_if
  import serial_mac_pkg::*;
#(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int Pw = 4
);
  localparam int L = ac_w(M, Pa);

  logic              in_valid;
  logic              in_ready;
  logic [M*Pa-1:0]   act_i;
  logic [M*Pw-1:0]   wgt_i;
  logic [L+Pw-1:0]   ac2_q;
  logic [L:0]        inr_ac2;
  logic              w_and_s;
  logic              cl_en;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_valid, act_i, wgt_i, ac2_q, out_ready,
    output in_ready, inr_ac2, w_and_s, cl_en, out_valid
  );

  modport master (
    output in_valid, act_i, wgt_i, ac2_q, out_ready,
    input  in_ready, inr_ac2, w_and_s, cl_en, out_valid
  );
endinterface

// File: rtl/serial_mac_ac1_seq_ac1_tree.sv
// Combinational masked adder tree: sum of activations whose weight bit is set.
module ac1_tree
  import serial_mac_pkg::*;
#(
  parameter int M  = 16,
  parameter int Pa = 8
) (
  input  logic [M*Pa-1:0]        act,
  input  logic [M-1:0]           wbit,
  output logic [ac_w(M, Pa)-1:0] p
);
  localparam int LV = $clog2(M);

  genvar gi, gj;
  generate
    // Level gi holds M>>gi partial sums, each Pa+gi bits wide.
    for (gi = 0; gi <= LV; gi++) begin : lvl
      localparam int N = M >> gi;
      localparam int W = Pa + gi;
      logic [W-1:0] sum [N];
      if (gi == 0) begin : leaf
        for (gj = 0; gj < N; gj++) begin : mask
          assign sum[gj] = wbit[gj] ? act[gj*Pa +: Pa] : '0;
        end
      end else begin : node
        for (gj = 0; gj < N; gj++) begin : add
          assign sum[gj] = {1'b0, lvl[gi-1].sum[2*gj]} + {1'b0, lvl[gi-1].sum[2*gj+1]};
        end
      end
    end
  endgenerate

  assign p = lvl[LV].sum[0];
endmodule

// File: rtl/serial_mac_ac1_seq.sv
// Bit-serial AC1 sequencer: walks weights LSB-first and drives the AC2 shift-register accumulator.
module serial_mac_ac1_seq
  import serial_mac_pkg::*;
#(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int Pw = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_mac_ac1_seq_if.slave  bus
);
  localparam int L  = ac_w(M, Pa);
  localparam int CW = $clog2(Pw);
  localparam logic [CW-1:0] CNT_LAST = CW'(Pw - 1);

  smac_state_t       state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [M*Pa-1:0]   act_reg, act_next;
  logic [M*Pw-1:0]   wgt_reg, wgt_next;
  logic [M-1:0]      wbit;
  logic [L-1:0]      p;

  // The low AC2 bits are shifted by the register itself and never enter the adder.
  logic unused_ac2_low;
  assign unused_ac2_low = ^bus.ac2_q[Pw-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : bit_sel
      logic [Pw-1:0] wk;
      assign wk       = wgt_reg[gi*Pw +: Pw];
      assign wbit[gi] = wk[cnt_reg];
    end
  endgenerate

  ac1_tree #(.M(M), .Pa(Pa)) u_tree (
    .act  (act_reg),
    .wbit (wbit),
    .p    (p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      act_reg   <= '0;
      wgt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      act_reg   <= act_next;
      wgt_reg   <= wgt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    act_next      = act_reg;
    wgt_next      = wgt_reg;
    bus.in_ready  = 1'b0;
    bus.w_and_s   = 1'b0;
    bus.out_valid = 1'b0;
    bus.cl_en     = 1'b0;
    bus.inr_ac2   = '0;
    case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          act_next   = bus.act_i;
          wgt_next   = bus.wgt_i;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        bus.w_and_s = 1'b1;
        // Partial sum lands at the top of AC2 while the register shifts right by one.
        bus.inr_ac2 = {1'b0, p} + {1'b0, bus.ac2_q[L+Pw-1:Pw]};
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          bus.cl_en  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_mac_ac1_seq.sv
// Directed bench for the AC1 sequencer driving a bench-side AC2 shift register (M=4, Pa=8, Pw=4).
module tb_serial_mac_ac1_seq;
  import serial_mac_pkg::*;

  localparam int M  = 4;
  localparam int Pa = 8;
  localparam int Pw = 4;
  localparam int L  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  serial_mac_ac1_seq_if #(.M(M), .Pa(Pa), .Pw(Pw)) bus ();

  serial_mac_ac1_seq #(.M(M), .Pa(Pa), .Pw(Pw)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // AC2 shift-register accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           bus.ac2_q <= '0;
    else if (bus.cl_en)   bus.ac2_q <= '0;
    else if (bus.w_and_s) bus.ac2_q <= {bus.inr_ac2, bus.ac2_q[Pw-1:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dot(input logic [31:0] a, input logic [15:0] w);
    int s = 0;
    for (int k = 0; k < M; k++) s += int'(a[k*8 +: 8]) * int'(w[k*4 +: 4]);
    return s;
  endfunction

  // One full transaction: accept, Pw RUN cycles, DONE check, release with out_ready.
  task automatic run_set(input string tag, input logic [31:0] a, input logic [15:0] w,
                         input logic [13:0] exp, input bit chk_inr, input logic [43:0] inr_exp);
    bus.act_i    = a;
    bus.wgt_i    = w;
    bus.in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < Pw; i++) begin
      chk({tag, ".w_and_s"}, 32'(bus.w_and_s), 1);
      chk({tag, ".out_valid_run"}, 32'(bus.out_valid), 0);
      if (chk_inr) chk({tag, ".inr_ac2"}, 32'(bus.inr_ac2), 32'(inr_exp[i*11 +: 11]));
      step();
    end
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 1);
    chk({tag, ".w_and_s_done"}, 32'(bus.w_and_s), 0);
    chk({tag, ".ac2_q"}, 32'(bus.ac2_q), 32'(exp));
    $display("set %s: act=%h wgt=%h ac2_q=%0d expected=%0d", tag, a, w, bus.ac2_q, exp);
    bus.out_ready = 1'b1;
    #1;
    chk({tag, ".cl_en"}, 32'(bus.cl_en), 1);
    step();
    bus.out_ready = 1'b0;
    chk({tag, ".ac2_clr"}, 32'(bus.ac2_q), 0);
    chk({tag, ".in_ready_after"}, 32'(bus.in_ready), 1);
    chk({tag, ".cl_en_after"}, 32'(bus.cl_en), 0);
  endtask

  initial begin
    logic [13:0] exp_q;
    logic [13:0] held;
    int          last_acc;
    int          n_res;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.act_i     = '0;
    bus.wgt_i     = '0;

    // Reset state
    step();
    step();
    chk("rst.in_ready", 32'(bus.in_ready), 1);
    chk("rst.w_and_s", 32'(bus.w_and_s), 0);
    chk("rst.cl_en", 32'(bus.cl_en), 0);
    chk("rst.out_valid", 32'(bus.out_valid), 0);
    chk("rst.inr_ac2", 32'(bus.inr_ac2), 0);
    chk("rst.ac2_q", 32'(bus.ac2_q), 0);
    rst_n = 1'b1;
    step();

    // Full-scale operands, per-cycle feedback sequence, all-zero weights
    run_set("max", 32'hFFFF_FFFF, 16'hFFFF, 14'd15300, 1'b0, '0);
    run_set("ramp", 32'h0403_0201, 16'h8421, 14'd49, 1'b1, {11'd6, 11'd4, 11'd2, 11'd1});
    run_set("zero_w", $urandom, 16'h0000, 14'd0, 1'b0, '0);
    run_set("zero_a", 32'h0, 16'hFFFF, 14'd0, 1'b0, '0);

    // Early out_ready must not disturb IDLE/RUN; DONE held for 10 cycles with competing input
    bus.out_ready = 1'b1;
    #1;
    chk("early.cl_en_idle", 32'(bus.cl_en), 0);
    bus.act_i    = 32'h0A14_1E28;
    bus.wgt_i    = 16'h1234;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("early.cl_en_run", 32'(bus.cl_en), 0);
    bus.out_ready = 1'b0;
    step();
    step();
    step();
    chk("hold.ac2_q", 32'(bus.ac2_q), 300);
    held = bus.ac2_q;
    bus.in_valid = 1'b1;
    bus.act_i    = 32'hFFFF_FFFF;
    bus.wgt_i    = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      chk("hold.out_valid", 32'(bus.out_valid), 1);
      chk("hold.in_ready", 32'(bus.in_ready), 0);
      chk("hold.cl_en", 32'(bus.cl_en), 0);
      chk("hold.stable", 32'(bus.ac2_q), 32'(held));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("hold.cl_en_rel", 32'(bus.cl_en), 1);
    step();
    bus.out_ready = 1'b0;
    chk("hold.ac2_clr", 32'(bus.ac2_q), 0);
    chk("hold.in_ready_rel", 32'(bus.in_ready), 1);
    $display("set hold: ac2_q=%0d expected=300", held);

    // Reset pulse while RUN at cnt=2
    bus.act_i    = 32'h0403_0201;
    bus.wgt_i    = 16'h8421;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("mid.inr_cnt2", 32'(bus.inr_ac2), 4);
    rst_n = 1'b0;
    #1;
    chk("mid.in_ready", 32'(bus.in_ready), 1);
    chk("mid.w_and_s", 32'(bus.w_and_s), 0);
    chk("mid.out_valid", 32'(bus.out_valid), 0);
    chk("mid.cl_en", 32'(bus.cl_en), 0);
    chk("mid.inr_ac2", 32'(bus.inr_ac2), 0);
    chk("mid.ac2_q", 32'(bus.ac2_q), 0);
    step();
    rst_n = 1'b1;
    step();
    run_set("after_rst", 32'h0403_0201, 16'h8421, 14'd49, 1'b1, {11'd6, 11'd4, 11'd2, 11'd1});

    // Back-to-back random sets, in_valid held high, random out_ready
    exp_q    = '0;
    last_acc = -1;
    n_res    = 0;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.act_i     = $urandom;
      bus.wgt_i     = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        chk("b2b.result", 32'(bus.ac2_q), 32'(exp_q));
        n_res++;
        $display("set b2b#%0d: ac2_q=%0d expected=%0d", n_res, bus.ac2_q, exp_q);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q = 14'(dot(bus.act_i, bus.wgt_i));
        if (last_acc >= 0) chk("b2b.interval_ok", 32'((cyc - last_acc) >= Pw + 2), 1);
        last_acc = cyc;
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk("b2b.count_ok", 32'(n_res >= 20), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
